// File: rtl/edge_pulse_gen_pkg.sv
// Shared edge-mode codes, repeat-FSM state encodings and a small sizing helper
// for the multi-channel edge pulse generator.
package edge_pulse_gen_pkg;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_pulse_gen_if.sv
// Button-side bundle of the edge pulse generator: raw inputs and mode in,
// debounced levels and pulses out.
interface edge_pulse_gen_if #(
    parameter int N = 4
);
    logic [N-1:0] InputPulse;
    logic [1:0]   Mode;
    logic [N-1:0] Level;
    logic [N-1:0] OneShot;

    modport master (
        output InputPulse,
        output Mode,
        input  Level,
        input  OneShot
    );

    modport slave (
        input  InputPulse,
        input  Mode,
        output Level,
        output OneShot
    );

endinterface

// File: rtl/edge_pulse_gen_channel.sv
// One channel: 2-FF synchroniser, debouncer, mode-qualified edge detect,
// hold-to-repeat FSM and a reloadable pulse stretcher.
module edge_pulse_channel
    import edge_pulse_gen_pkg::*;
#(
    parameter bit IDLE_LEVEL    = 1'b1,
    parameter int DEBOUNCE      = 4,
    parameter int PULSE_WIDTH   = 1,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic       CLOCK,
    input  logic       Reset,
    input  logic       rawIn,
    input  logic [1:0] mode,
    output logic       level,
    output logic       oneShot
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(PULSE_WIDTH + 1);
    localparam int HW = $clog2(maxInt(HOLD_CYCLES, REPEAT_CYCLES) + 1);

    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;
    localparam logic [PW-1:0] PCNT_LOAD   = PW'(PULSE_WIDTH);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_MAX    = '1;

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          levelToggle;
    logic          edgeMatch;
    logic          edgeFlag;
    logic [1:0]    state;
    logic [1:0]    stateNext;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcntNext;
    logic          repeatTrig;
    logic          repeatable;
    logic          atActive;
    logic          trigger;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcntNext;

    always_ff @(posedge CLOCK or posedge Reset) begin
        if (Reset) begin
            s1 <= IDLE_LEVEL;
            s2 <= IDLE_LEVEL;
        end else begin
            s1 <= rawIn;
            s2 <= s1;
        end
    end

    assign levelToggle = (s2 != level) && (cnt == CNT_LAST);

    // Mode is judged against the level being entered, sampled on the toggle edge itself
    always_comb begin
        edgeMatch = 1'b0;
        case (mode)
            MODE_RISE: edgeMatch = ~level;
            MODE_FALL: edgeMatch = level;
            MODE_BOTH: edgeMatch = 1'b1;
            default:   edgeMatch = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK or posedge Reset) begin
        if (Reset) begin
            level    <= IDLE_LEVEL;
            cnt      <= '0;
            edgeFlag <= 1'b0;
        end else begin
            edgeFlag <= levelToggle && edgeMatch;
            if (s2 == level) begin
                cnt <= '0;
            end else if (levelToggle) begin
                level <= ~level;
                cnt   <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign repeatable = REPEAT_EN && ((mode == MODE_RISE) || (mode == MODE_FALL));
    assign atActive   = (level == (mode == MODE_RISE));

    // Leaving the active level is checked first so a release beats a due repeat
    always_comb begin
        stateNext  = state;
        hcntNext   = hcnt;
        repeatTrig = 1'b0;
        case (state)
            ST_IDLE: begin
                if (edgeFlag && repeatable && atActive) begin
                    stateNext = ST_HELD;
                    hcntNext  = '0;
                end
            end
            ST_HELD, ST_REPEAT: begin
                if (!repeatable || !atActive) begin
                    stateNext = ST_IDLE;
                    hcntNext  = '0;
                end else if (hcnt == ((state == ST_HELD) ? HOLD_LAST : REPEAT_LAST)) begin
                    repeatTrig = 1'b1;
                    stateNext  = ST_REPEAT;
                    hcntNext   = '0;
                end else if (hcnt != HCNT_MAX) begin
                    hcntNext = hcnt + 1'b1;
                end
            end
            default: begin
                stateNext = ST_IDLE;
                hcntNext  = '0;
            end
        endcase
    end

    assign trigger = edgeFlag || repeatTrig;

    always_comb begin
        pcntNext = '0;
        if (trigger) begin
            pcntNext = PCNT_LOAD;
        end else if (pcnt != '0) begin
            pcntNext = pcnt - 1'b1;
        end
    end

    always_ff @(posedge CLOCK or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            hcnt    <= '0;
            pcnt    <= '0;
            oneShot <= 1'b0;
        end else begin
            state   <= stateNext;
            hcnt    <= hcntNext;
            pcnt    <= pcntNext;
            oneShot <= (pcntNext != '0);
        end
    end

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel edge pulse generator: N independent debounced one-shot channels
// sharing clock, reset and edge mode.
module edge_pulse_gen
    import edge_pulse_gen_pkg::*;
#(
    parameter int N             = 4,
    parameter bit IDLE_LEVEL    = 1'b1,
    parameter int DEBOUNCE      = 4,
    parameter int PULSE_WIDTH   = 1,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic            CLOCK,
    input  logic            Reset,
    edge_pulse_gen_if.slave bus
);

    logic [N-1:0] levelVec;
    logic [N-1:0] oneShotVec;

    for (genvar i = 0; i < N; i++) begin : gChannel
        edge_pulse_channel #(
            .IDLE_LEVEL   (IDLE_LEVEL),
            .DEBOUNCE     (DEBOUNCE),
            .PULSE_WIDTH  (PULSE_WIDTH),
            .REPEAT_EN    (REPEAT_EN),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) uChannel (
            .CLOCK  (CLOCK),
            .Reset  (Reset),
            .rawIn  (bus.InputPulse[i]),
            .mode   (bus.Mode),
            .level  (levelVec[i]),
            .oneShot(oneShotVec[i])
        );
    end

    assign bus.Level   = levelVec;
    assign bus.OneShot = oneShotVec;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed bench for edge_pulse_gen: default instance plus a DEBOUNCE=1,
// PULSE_WIDTH=3 instance for the pulse-stretch case.
module tb_edge_pulse_gen;
    import edge_pulse_gen_pkg::*;

    logic CLOCK = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    edge_pulse_gen_if #(.N(4)) busA ();
    edge_pulse_gen_if #(.N(4)) busB ();

    edge_pulse_gen #(.N(4)) dut (
        .CLOCK(CLOCK),
        .Reset(Reset),
        .bus  (busA)
    );

    edge_pulse_gen #(
        .N          (4),
        .DEBOUNCE   (1),
        .PULSE_WIDTH(3),
        .REPEAT_EN  (1'b0)
    ) dutWide (
        .CLOCK(CLOCK),
        .Reset(Reset),
        .bus  (busB)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] pulses, input logic [1:0] mode);
        busA.InputPulse = pulses;
        busA.Mode       = mode;
    endtask

    // Inputs change right after a falling-edge sample, so the next rising edge captures them
    initial begin
        Reset = 1'b1;
        applyStimulus(4'hF, MODE_FALL);
        busB.InputPulse = 4'hF;
        busB.Mode       = MODE_BOTH;

        @(negedge CLOCK);
        checkOutput("resetLevel", busA.Level, 4'hF);
        checkOutput("resetShot", busA.OneShot, 4'h0);
        #3;
        Reset = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge CLOCK);
            checkOutput("postResetLevel", busA.Level, 4'hF);
            checkOutput("postResetShot", busA.OneShot, 4'h0);
            checkOutput("postResetShotWide", busB.OneShot, 4'h0);
        end

        $display("[TB] falling-edge hold-to-repeat on ch0");
        applyStimulus(4'hE, MODE_FALL);
        for (int j = 1; j <= 56; j++) begin
            @(negedge CLOCK);
            checkOutput("holdLevel", busA.Level, (j >= 6 && j < 46) ? 4'hE : 4'hF);
            checkOutput("holdShot", busA.OneShot,
                        (j == 7 || j == 23 || j == 31 || j == 39) ? 4'h1 : 4'h0);
            if (j == 40) applyStimulus(4'hF, MODE_FALL);
        end

        $display("[TB] short glitch on ch1");
        applyStimulus(4'hD, MODE_FALL);
        for (int j = 1; j <= 14; j++) begin
            @(negedge CLOCK);
            if (j == 2) applyStimulus(4'hF, MODE_FALL);
            checkOutput("glitchLevel", busA.Level, 4'hF);
            checkOutput("glitchShot", busA.OneShot, 4'h0);
        end

        $display("[TB] both-edge mode on ch2");
        applyStimulus(4'hB, MODE_BOTH);
        for (int j = 1; j <= 40; j++) begin
            @(negedge CLOCK);
            checkOutput("bothLevel", busA.Level, (j >= 6 && j < 26) ? 4'hB : 4'hF);
            checkOutput("bothShot", busA.OneShot, (j == 7 || j == 27) ? 4'h4 : 4'h0);
            if (j == 20) applyStimulus(4'hF, MODE_BOTH);
        end

        $display("[TB] pulse stretch on wide instance");
        busB.InputPulse = 4'hE;
        for (int j = 1; j <= 12; j++) begin
            @(negedge CLOCK);
            checkOutput("stretchLevel", busB.Level, (j == 3 || j == 4) ? 4'hE : 4'hF);
            checkOutput("stretchShot", busB.OneShot, (j >= 4 && j <= 8) ? 4'h1 : 4'h0);
            if (j == 2) busB.InputPulse = 4'hF;
        end

        $display("[TB] rising-edge repeat on ch3 cut by reset");
        applyStimulus(4'h7, MODE_RISE);
        for (int j = 1; j <= 10; j++) begin
            @(negedge CLOCK);
            checkOutput("riseArmLevel", busA.Level, (j >= 6) ? 4'h7 : 4'hF);
            checkOutput("riseArmShot", busA.OneShot, 4'h0);
        end
        applyStimulus(4'hF, MODE_RISE);
        for (int j = 1; j <= 31; j++) begin
            @(negedge CLOCK);
            checkOutput("riseShot", busA.OneShot,
                        (j == 7 || j == 23 || j == 31) ? 4'h8 : 4'h0);
        end
        #1;
        Reset = 1'b1;
        #1;
        checkOutput("asyncResetShot", busA.OneShot, 4'h0);
        checkOutput("asyncResetLevel", busA.Level, 4'hF);
        @(negedge CLOCK);
        checkOutput("heldResetShot", busA.OneShot, 4'h0);
        #3;
        Reset = 1'b0;
        for (int j = 1; j <= 24; j++) begin
            @(negedge CLOCK);
            checkOutput("afterResetShot", busA.OneShot, 4'h0);
            checkOutput("afterResetLevel", busA.Level, 4'hF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
